// File: rtl/alu_arb_pkg.sv
// Shared constants, FSM state type and operand helper for the alu_arbiter block.
package alu_arb_pkg;

    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_ABS   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSD = 3'b111;

    localparam logic [7:0] MUL_MASK = 8'h0f;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    // MUL only sees the low nibble of each operand so the product fits in 8 bits.
    function automatic logic [7:0] mask_operand(input logic [2:0] op, input logic [7:0] v);
        return (op == OP_MUL) ? (v & MUL_MASK) : v;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Client request/response and ALU drive signals of the alu_arbiter.
// slave = arbiter view, master = clients plus ALU view.
interface alu_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_opcode;
    logic [15:0] req_data;
    logic [15:0] req_accum;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_data;
    logic [7:0]  alu_accum;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [7:0]  resp_result;
    logic        resp_zero;

    modport slave (
        input  req_valid, req_opcode, req_data, req_accum, alu_out, alu_zero, resp_ready,
        output req_ready, alu_opcode, alu_data, alu_accum, resp_valid, resp_result, resp_zero
    );

    modport master (
        output req_valid, req_opcode, req_data, req_accum, alu_out, alu_zero, resp_ready,
        input  req_ready, alu_opcode, alu_data, alu_accum, resp_valid, resp_result, resp_zero
    );

endinterface

// File: rtl/alu_arb_pick.sv
// Winner selection between the two requesters.
// ALU_ARB_RR_EN defined: alternate on contention; undefined: requester 0 has fixed priority.
module alu_arb_pick (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_RR_EN
    // On contention favour the requester that was not granted last.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end
`else
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant_i;

    // Requester 0 always wins on contention.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = 2'b01;
            default: grant_o = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared registered ALU.
// Build option ALU_ARB_RR_EN selects round-robin instead of fixed priority (see alu_arb_pick).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  accum_q, accum_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [7:0]  result_q, result_d;
    logic        zero_q, zero_d;

    logic [1:0]  grant_s;
    logic        win_s;
    logic        xfer_s;
    logic [2:0]  win_op_s;
    logic [7:0]  win_data_s;
    logic [7:0]  win_accum_s;

    alu_arb_pick u_pick (
        .req_valid_i  (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_s)
    );

    assign win_s       = grant_s[1];
    assign win_op_s    = win_s ? bus.req_opcode[5:3] : bus.req_opcode[2:0];
    assign win_data_s  = win_s ? bus.req_data[15:8]  : bus.req_data[7:0];
    assign win_accum_s = win_s ? bus.req_accum[15:8] : bus.req_accum[7:0];

    // Ready is gated by reset_n so nothing is offered while reset is held.
    assign bus.req_ready = ((state_q == ST_IDLE) && reset_n) ? grant_s : 2'b00;
    assign xfer_s        = |(bus.req_ready & bus.req_valid);

    assign bus.alu_opcode  = op_q;
    assign bus.alu_data    = data_q;
    assign bus.alu_accum   = accum_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        data_d       = data_q;
        accum_d      = accum_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    op_d         = win_op_s;
                    data_d       = mask_operand(win_op_s, win_data_s);
                    accum_d      = mask_operand(win_op_s, win_accum_s);
                    owner_d      = win_s;
                    last_grant_d = win_s;
                    cnt_d        = 3'(ALU_LAT - 1);
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_CAPTURE: begin
                result_d     = bus.alu_out;
                zero_d       = bus.alu_zero;
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 3'b000;
            data_q       <= 8'h00;
            accum_q      <= 8'h00;
            cnt_q        <= 3'd0;
            resp_valid_q <= 2'b00;
            result_q     <= 8'h00;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            data_q       <= data_d;
            accum_q      <= accum_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int ALU_LAT = 1;

    typedef struct packed {
        logic       owner;
        logic [7:0] res;
        logic       z;
    } exp_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   fails;
    exp_t sb[$];
    exp_t mon_e;
    logic mon_own;
    logic [7:0] alu_pipe [ALU_LAT];

    alu_arbiter_if bus ();

    alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
        logic [15:0] p;
        p = 16'(d) * 16'(a);
        case (op)
            OP_PASSA: return a;
            OP_ADD:   return a + d;
            OP_SUB:   return a - d;
            OP_AND:   return a & d;
            OP_XOR:   return a ^ d;
            OP_ABS:   return a[7] ? (8'h00 - a) : a;
            OP_MUL:   return p[7:0];
            default:  return d;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(bus.alu_opcode, bus.alu_data, bus.alu_accum);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign bus.alu_out  = alu_pipe[ALU_LAT-1];
    assign bus.alu_zero = (alu_pipe[ALU_LAT-1] == 8'h00);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (reset_n && bus.resp_valid != 2'b00) begin
            mon_own = bus.resp_valid[1];
            if (bus.resp_ready[mon_own]) begin
                if (sb.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL resp_unexpected: got resp_valid %b, expected none", bus.resp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_valid", 32'(bus.resp_valid), mon_e.owner ? 32'h2 : 32'h1);
                    chk("resp_result", 32'(bus.resp_result), 32'(mon_e.res));
                    chk("resp_zero", 32'(bus.resp_zero), 32'(mon_e.z));
                end
            end
        end
    end

    task automatic wait_grant(input logic [1:0] exp_mask);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                chk("req_ready_grant", 32'(bus.req_ready), 32'(exp_mask));
                seen = 1'b1;
            end
        end
        if (!seen) chk("grant_timeout", 32'h0, 32'(exp_mask));
    endtask

    task automatic push_exp(input logic own, input logic [7:0] r, input logic z);
        exp_t e;
        e.owner = own;
        e.res   = r;
        e.z     = z;
        sb.push_back(e);
    endtask

    task automatic send(input int idx, input logic [2:0] op, input logic [7:0] d, input logic [7:0] a,
                        input logic [7:0] er, input logic ez, input bit push);
        @(posedge clk); #1;
        bus.req_opcode[idx*3 +: 3] = op;
        bus.req_data[idx*8 +: 8]   = d;
        bus.req_accum[idx*8 +: 8]  = a;
        bus.req_valid[idx]         = 1'b1;
        wait_grant((idx == 1) ? 2'b10 : 2'b01);
        if (push) push_exp(idx == 1, er, ez);
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        fails   = 0;
        reset_n = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_opcode = 6'h00;
        bus.req_data   = 16'h0000;
        bus.req_accum  = 16'h0000;
        bus.resp_ready = 2'b11;
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // ADD from requester 0, with latency probe.
        send(0, OP_ADD, 8'hD6, 8'hDF, 8'hB5, 1'b0, 1'b1);
        @(negedge clk); chk("lat_e0", 32'(bus.resp_valid), 32'h0);
        @(negedge clk); chk("lat_e1", 32'(bus.resp_valid), 32'h0);
        @(negedge clk); chk("lat_e2", 32'(bus.resp_valid), 32'h1);
        repeat (3) @(posedge clk);

        // MUL from requester 1: operands masked to the low nibble.
        send(1, OP_MUL, 8'hD6, 8'hDF, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        chk("mul_alu_opcode", 32'(bus.alu_opcode), 32'(OP_MUL));
        chk("mul_alu_data", 32'(bus.alu_data), 32'h06);
        chk("mul_alu_accum", 32'(bus.alu_accum), 32'h0F);
        repeat (4) @(posedge clk);

        // Asynchronous reset while the op is in ISSUE; no response expected.
        send(0, OP_AND, 8'hD6, 8'hDF, 8'h00, 1'b0, 1'b0);
        #1 bus.req_valid[1] = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("mid_rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);
        chk("mid_rst_alu_data", 32'(bus.alu_data), 32'h00);
        chk("mid_rst_alu_accum", 32'(bus.alu_accum), 32'h00);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("mid_rst_resp_result", 32'(bus.resp_result), 32'h00);
        chk("mid_rst_resp_zero", 32'(bus.resp_zero), 32'h0);
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_req_ready", 32'(bus.req_ready), 32'h0);
        end

        // Contention: requester 0 ADD, requester 1 XOR, both held valid.
        @(posedge clk); #1;
        bus.req_opcode = {OP_XOR, OP_ADD};
        bus.req_data   = 16'hD6D6;
        bus.req_accum  = 16'hDFDF;
        bus.req_valid  = 2'b11;
`ifdef ALU_ARB_RR_EN
        wait_grant(2'b01); push_exp(1'b0, 8'hB5, 1'b0); @(posedge clk); #1;
        wait_grant(2'b10); push_exp(1'b1, 8'h09, 1'b0); @(posedge clk); #1;
        wait_grant(2'b01); push_exp(1'b0, 8'hB5, 1'b0); @(posedge clk); #1;
`else
        for (int k = 0; k < 3; k++) begin
            wait_grant(2'b01); push_exp(1'b0, 8'hB5, 1'b0); @(posedge clk); #1;
        end
`endif
        bus.req_valid = 2'b00;
        repeat (6) @(posedge clk);

        // Zero flag under backpressure; non-owner ready must be ignored.
        #1 bus.resp_ready = 2'b10;
        send(0, OP_XOR, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1);
        bus.req_opcode[5:3] = OP_AND;
        bus.req_data[15:8]  = 8'hD6;
        bus.req_accum[15:8] = 8'hDF;
        bus.req_valid[1]    = 1'b1;
        for (int n = 0; n < 20 && bus.resp_valid == 2'b00; n++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
            chk("bp_resp_result", 32'(bus.resp_result), 32'h00);
            chk("bp_resp_zero", 32'(bus.resp_zero), 32'h1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1 bus.resp_ready = 2'b11;
        wait_grant(2'b10);
        push_exp(1'b1, 8'hD6, 1'b0);
        @(posedge clk); #1 bus.req_valid = 2'b00;

        repeat (10) @(posedge clk);
        #1 chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit registered `alu`. It accepts operation requests over valid/ready handshakes and grants one requester at a time. It drives the ALU's opcode and operand inputs, waits out the ALU's registered latency, and returns the result and zero flag to the granted requester. It sits between the two client blocks and the single `alu` instance. The top level wires `alu_out`/`zero` back into this block.

## Interface
- `ALU_LAT`, 1, clock edges between ALU inputs being stable and `alu_out`/`zero` being valid (1..7)
- `clk`  in  1  system clock, rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid, bit i = requester i
- `req_ready`  out  2  per-requester accept; a transfer occurs when valid and ready are both high on a rising edge
- `req_opcode`  in  6  {op1, op0}, 3-bit ALU opcodes
- `req_data`  in  16  {data1, data0}
- `req_accum`  in  16  {accum1, accum0}
- `alu_opcode`  out  3  to ALU `opcode`
- `alu_data`  out  8  to ALU `data`
- `alu_accum`  out  8  to ALU `accum`
- `alu_out`  in  8  from ALU
- `alu_zero`  in  1  from ALU `zero`
- `resp_valid`  out  2  one-hot; the bit of the requester that owns the response
- `resp_ready`  in  2  per-requester response accept
- `resp_result`  out  8  captured `alu_out`
- `resp_zero`  out  1  captured `alu_zero`

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - Pick a winner among `req_valid`.
  - `req_ready` is combinational and high only for the winner, only in IDLE.
  - On transfer: latch the winner's opcode/data/accum into the drive registers, record `owner`, go to ISSUE.
- **Operand masking:** if the latched opcode is 3'b110 (MUL), the drive registers store `data & 8'h0f` and `accum & 8'h0f`. All other opcodes pass unmasked.
- **ISSUE**
  - Drive registers feed the `alu_*` outputs.
  - A latency counter loads `ALU_LAT-1` on entry and counts down.
  - When the counter is 0, go to CAPTURE.
- **CAPTURE:** latch `alu_out`/`alu_zero` into `resp_result`/`resp_zero` and go to RESP.
- **RESP**
  - `resp_valid[owner]`=1, the other bit is 0.
  - Hold until `resp_ready[owner]`, then go to IDLE.
  - `resp_ready` of the non-owner is ignored.
- The drive registers hold their values through CAPTURE and RESP. They change only on a new transfer.
- **Arbitration:** when both requesters are valid, grant the requester not granted last (`last_grant` register, reset value 1 so requester 0 wins first). A single valid requester always wins.
- A requester whose `req_valid` drops before transfer is simply not granted. No state is kept for it.

## Timing
- **Reset values:**
  - FSM = IDLE, `req_ready` = 2'b00 while reset is asserted.
  - `alu_opcode` = 3'b000, `alu_data` = 8'h00, `alu_accum` = 8'h00.
  - `resp_valid` = 2'b00, `resp_result` = 8'h00, `resp_zero` = 0, `last_grant` = 1.
- **Latency:** with transfer at edge E0, `resp_valid` rises after edge E0+`ALU_LAT`+1. For `ALU_LAT`=1 that is 2 edges.
- **Throughput:** if `resp_ready` is already high, the earliest next transfer is at edge E0+`ALU_LAT`+3. The block never accepts while busy.
- **Deassertion:** `resp_valid` drops on the edge where `resp_ready[owner]` is sampled high. `req_ready` can be high in the next cycle.
- **Reset mid-operation:** an asynchronous return to the reset values; an in-flight op is discarded with no response.
- **Width:** results are 8 bits exactly as the ALU delivers them; no extension.

## Configuration
- `ALU_ARB_RR_EN`
  - Defined: round-robin as described above.
  - Undefined: fixed priority, requester 0 always wins when both are valid. The `last_grant` register is not built.

## Structure
- Package `alu_arb_pkg` holds:
  - opcode constants PASSA=000, ADD=001, SUB=010, AND=011, XOR=100, ABS=101, MUL=110, PASSD=111
  - the FSM state enum
  - `MUL_MASK`=8'h0f
- Sub-module `alu_arb_pick`: combinational winner selection from `req_valid` and `last_grant`. The macro is confined to it.
- The `alu` instance is not inside this block.

## Test plan
- **Reset:** assert `reset_n`=0 mid-ISSUE -> all outputs go to reset values immediately; after release `req_ready`=00 until a request arrives.
- **ADD:** requester 0 sends ADD, data=D6, accum=DF, `ALU_LAT`=1 -> `resp_valid`=01 two edges after transfer, `resp_result`=B5, `resp_zero`=0.
- **MUL masking:** requester 1 sends MUL, data=D6, accum=DF -> ALU sees 06 and 0F, `resp_result`=5A, `resp_valid`=10.
- **Contention (`ALU_ARB_RR_EN` defined):**
  - Both requesters valid with ADD/XOR, D6/DF -> requester 0 is served first (B5), then requester 1 (XOR = 09).
  - Both valid again -> requester 0 wins again.
- **Contention (macro undefined):** both requesters valid continuously -> requester 0 is served every time; requester 1 is never granted.
- **Zero flag and backpressure:** XOR with data=55, accum=55, `resp_ready` held low for 5 cycles -> `resp_valid` stays high with `resp_result`=00 and `resp_zero`=1; `req_ready` stays 00 until `resp_ready` rises.
